// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM subsystem.
//
// Contents:
//   - Default address and data widths for the SPI RAM path.
//   - State encodings for the two-port arbiter, plus a typed enum built on them.
//   - Port index constants: CPU = port 0, loader/debug = port 1.
package spi_ram_pkg;

  localparam int unsigned ADDR_BITS_DEF = 16;
  localparam int unsigned DATA_BITS_DEF = 16;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;
  localparam logic [1:0] ARB_DONE  = 2'd3;

  localparam logic PORT_CPU    = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = ARB_IDLE,
    StIssue = ARB_ISSUE,
    StWait  = ARB_WAIT,
    StDone  = ARB_DONE
  } arb_state_e;

endpackage

// File: rtl/spi_ram_arbiter.sv
// Two-port arbiter in front of the single SPI RAM controller.
//
// Port 0 (CPU) and port 1 (loader/debug) each use a level request that is held
// until a one-cycle done pulse. The arbiter picks a winner in idle, issues one
// start_read/start_write pulse, waits for the controller busy flag to drop, and
// returns read data to the granted port. All outputs are registered.
//
// Configuration macro:
//   SPI_ARB_FIXED_PRIO_EN - when defined, port 0 always wins ties and there is
//                           no round-robin pointer. Default is round-robin.
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_pN_req/we/addr/wdata         port N request, direction, address, write data
//   o_pN_rdata, o_pN_done          port N read data (held), completion pulse
//   o_ram_addr, o_ram_data_in      controller address / write data
//   o_ram_start_read/write         one-cycle controller start pulses
//   i_ram_data_out, i_ram_busy     controller read data / busy
//   o_grant                        port owning the current or last transaction
//   o_arb_busy                     high while not idle
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int unsigned ADDR_BITS = ADDR_BITS_DEF,
  parameter int unsigned DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_p0_req,
  input  logic                 i_p0_we,
  input  logic [ADDR_BITS-1:0] i_p0_addr,
  input  logic [DATA_BITS-1:0] i_p0_wdata,
  output logic [DATA_BITS-1:0] o_p0_rdata,
  output logic                 o_p0_done,
  input  logic                 i_p1_req,
  input  logic                 i_p1_we,
  input  logic [ADDR_BITS-1:0] i_p1_addr,
  input  logic [DATA_BITS-1:0] i_p1_wdata,
  output logic [DATA_BITS-1:0] o_p1_rdata,
  output logic                 o_p1_done,
  output logic [ADDR_BITS-1:0] o_ram_addr,
  output logic [DATA_BITS-1:0] o_ram_data_in,
  output logic                 o_ram_start_read,
  output logic                 o_ram_start_write,
  input  logic [DATA_BITS-1:0] i_ram_data_out,
  input  logic                 i_ram_busy,
  output logic                 o_grant,
  output logic                 o_arb_busy
);

  arb_state_e           r_state;
  logic                 r_we;
  logic                 r_grant;
  logic                 r_arb_busy;
  logic                 r_start_read;
  logic                 r_start_write;
  logic                 r_p0_done;
  logic                 r_p1_done;
  logic [ADDR_BITS-1:0] r_ram_addr;
  logic [DATA_BITS-1:0] r_ram_data_in;
  logic [DATA_BITS-1:0] r_p0_rdata;
  logic [DATA_BITS-1:0] r_p1_rdata;

  logic                 w_any_req;
  logic                 w_winner;
  logic                 w_sel_we;
  logic [ADDR_BITS-1:0] w_sel_addr;
  logic [DATA_BITS-1:0] w_sel_wdata;

`ifdef SPI_ARB_FIXED_PRIO_EN
  // Port 0 wins whenever it requests; port 1 may starve.
  function automatic logic pick_winner(input logic req0, input logic req1);
    if (req0) return PORT_CPU;
    if (req1) return PORT_LOADER;
    return PORT_CPU;
  endfunction

  assign w_winner = pick_winner(i_p0_req, i_p1_req);
`else
  logic r_last;

  // On a tie the port that did not own the previous grant wins.
  function automatic logic pick_winner(input logic req0, input logic req1, input logic last);
    if (req0 && req1) return ~last;
    if (req1) return PORT_LOADER;
    return PORT_CPU;
  endfunction

  assign w_winner = pick_winner(i_p0_req, i_p1_req, r_last);
`endif

  assign w_any_req = i_p0_req | i_p1_req;

  always_comb begin
    w_sel_we    = i_p0_we;
    w_sel_addr  = i_p0_addr;
    w_sel_wdata = i_p0_wdata;
    if (w_winner == PORT_LOADER) begin
      w_sel_we    = i_p1_we;
      w_sel_addr  = i_p1_addr;
      w_sel_wdata = i_p1_wdata;
    end
  end

  // Starts are loaded on the idle->issue edge so they are high exactly during ISSUE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_we          <= 1'b0;
      r_grant       <= 1'b0;
      r_arb_busy    <= 1'b0;
      r_start_read  <= 1'b0;
      r_start_write <= 1'b0;
      r_p0_done     <= 1'b0;
      r_p1_done     <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_data_in <= '0;
      r_p0_rdata    <= '0;
      r_p1_rdata    <= '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
      r_last        <= PORT_LOADER;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_state       <= StIssue;
            r_grant       <= w_winner;
            r_we          <= w_sel_we;
            r_ram_addr    <= w_sel_addr;
            r_ram_data_in <= w_sel_wdata;
            r_start_read  <= ~w_sel_we;
            r_start_write <= w_sel_we;
            r_arb_busy    <= 1'b1;
`ifndef SPI_ARB_FIXED_PRIO_EN
            r_last        <= w_winner;
`endif
          end
        end
        StIssue: begin
          r_start_read  <= 1'b0;
          r_start_write <= 1'b0;
          r_state       <= StWait;
        end
        StWait: begin
          // Controller busy is already up by the first WAIT edge.
          if (!i_ram_busy) begin
            if (!r_we) begin
              if (r_grant == PORT_LOADER) r_p1_rdata <= i_ram_data_out;
              else                        r_p0_rdata <= i_ram_data_out;
            end
            if (r_grant == PORT_LOADER) r_p1_done <= 1'b1;
            else                        r_p0_done <= 1'b1;
            r_state <= StDone;
          end
        end
        StDone: begin
          // Requests are not sampled here; the requester drops req on this edge.
          r_p0_done  <= 1'b0;
          r_p1_done  <= 1'b0;
          r_arb_busy <= 1'b0;
          r_state    <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_p0_rdata        = r_p0_rdata;
  assign o_p0_done         = r_p0_done;
  assign o_p1_rdata        = r_p1_rdata;
  assign o_p1_done         = r_p1_done;
  assign o_ram_addr        = r_ram_addr;
  assign o_ram_data_in     = r_ram_data_in;
  assign o_ram_start_read  = r_start_read;
  assign o_ram_start_write = r_start_write;
  assign o_grant           = r_grant;
  assign o_arb_busy        = r_arb_busy;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed self-checking bench for spi_ram_arbiter with a behavioural controller.
module tb_spi_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [15:0] p0_rdata, p1_rdata, ram_addr, ram_data_in, ram_data_out;
  logic        p0_done, p1_done, ram_start_read, ram_start_write, ram_busy, grant, arb_busy;

  int checks = 0;
  int errors = 0;
  int asrt_fail = 0;
  int k_cfg = 4;
  int cnt;
  int sr_cnt = 0, sw_cnt = 0, d0_cnt = 0, d1_cnt = 0;
  logic [15:0] st_addr, st_data;
  logic        prev_start;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.ADDR_BITS(16), .DATA_BITS(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
    .o_p0_rdata(p0_rdata), .o_p0_done(p0_done),
    .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
    .o_p1_rdata(p1_rdata), .o_p1_done(p1_done),
    .o_ram_addr(ram_addr), .o_ram_data_in(ram_data_in),
    .o_ram_start_read(ram_start_read), .o_ram_start_write(ram_start_write),
    .i_ram_data_out(ram_data_out), .i_ram_busy(ram_busy),
    .o_grant(grant), .o_arb_busy(arb_busy)
  );

  function automatic logic [15:0] model_read(input logic [15:0] a);
    case (a)
      16'h0010: return 16'hBEEF;
      16'h0002: return 16'h5A5A;
      16'hFFFF: return 16'h0F0F;
      default:  return a ^ 16'hC3C3;
    endcase
  endfunction

  // Controller model: busy for k_cfg cycles starting the cycle after the start pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_busy     <= 1'b0;
      cnt          <= 0;
      ram_data_out <= '0;
    end else if (ram_start_read || ram_start_write) begin
      ram_busy <= 1'b1;
      cnt      <= k_cfg;
      if (ram_start_read) ram_data_out <= model_read(ram_addr);
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
    end else begin
      ram_busy <= 1'b0;
      cnt      <= 0;
    end
  end

  // Monitor: counts start pulses and done-high cycles, checks start pulse shape.
  always @(negedge clk) begin
    if (ram_start_read)  sr_cnt <= sr_cnt + 1;
    if (ram_start_write) sw_cnt <= sw_cnt + 1;
    if (ram_start_read || ram_start_write) begin
      st_addr <= ram_addr;
      st_data <= ram_data_in;
    end
    if (p0_done) d0_cnt <= d0_cnt + 1;
    if (p1_done) d1_cnt <= d1_cnt + 1;
    assert (!(ram_start_read && ram_start_write)) else begin
      $display("FAIL start_both read=%b write=%b required not both", ram_start_read,
               ram_start_write);
      asrt_fail <= asrt_fail + 1;
    end
    assert (!(prev_start && (ram_start_read || ram_start_write))) else begin
      $display("FAIL start_width start pulse lasted more than one cycle");
      asrt_fail <= asrt_fail + 1;
    end
    prev_start <= ram_start_read || ram_start_write;
  end

  task automatic run_txn(input bit port, input bit we, input logic [15:0] addr,
                         input logic [15:0] wdata, input int k, output bit ok);
    k_cfg = k;
    @(posedge clk); #1;
    if (port) begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (port ? p1_done : p0_done) begin
        ok = 1'b1;
        break;
      end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({p0_done, p1_done, ram_start_read, ram_start_write, grant, arb_busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 000000",
               {p0_done, p1_done, ram_start_read, ram_start_write, grant, arb_busy});
    end
    checks++;
    if ({ram_addr, ram_data_in} !== 32'h0) begin
      errors++;
      $display("FAIL reset_ram got %h required 00000000", {ram_addr, ram_data_in});
    end
    checks++;
    if ({p0_rdata, p1_rdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h required 00000000", {p0_rdata, p1_rdata});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_p0_read;
    int sr0 = sr_cnt, sw0 = sw_cnt, d00 = d0_cnt, d10 = d1_cnt;
    bit ok;
    run_txn(1'b0, 1'b0, 16'h0010, 16'h0000, 20, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL p0_read_timeout got %b required 1", ok); end
    checks++;
    if (sr_cnt - sr0 != 1 || sw_cnt - sw0 != 0) begin
      errors++;
      $display("FAIL p0_read_starts got rd=%0d wr=%0d required rd=1 wr=0", sr_cnt - sr0,
               sw_cnt - sw0);
    end
    checks++;
    if (st_addr !== 16'h0010) begin
      errors++; $display("FAIL p0_read_addr got %h required 0010", st_addr);
    end
    checks++;
    if (p0_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL p0_read_data got %h required beef", p0_rdata);
    end
    checks++;
    if (d0_cnt - d00 != 1 || d1_cnt - d10 != 0) begin
      errors++;
      $display("FAIL p0_read_done got d0=%0d d1=%0d required d0=1 d1=0", d0_cnt - d00,
               d1_cnt - d10);
    end
  endtask

  task automatic test_p1_write;
    int sr0 = sr_cnt, sw0 = sw_cnt, d00 = d0_cnt, d10 = d1_cnt;
    bit ok;
    run_txn(1'b1, 1'b1, 16'h1234, 16'hA55A, 3, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL p1_write_timeout got %b required 1", ok); end
    checks++;
    if (sw_cnt - sw0 != 1 || sr_cnt - sr0 != 0) begin
      errors++;
      $display("FAIL p1_write_starts got wr=%0d rd=%0d required wr=1 rd=0", sw_cnt - sw0,
               sr_cnt - sr0);
    end
    checks++;
    if (st_addr !== 16'h1234 || st_data !== 16'hA55A) begin
      errors++; $display("FAIL p1_write_bus got %h/%h required 1234/a55a", st_addr, st_data);
    end
    checks++;
    if (d1_cnt - d10 != 1 || d0_cnt - d00 != 0) begin
      errors++;
      $display("FAIL p1_write_done got d1=%0d d0=%0d required d1=1 d0=0", d1_cnt - d10,
               d0_cnt - d00);
    end
    checks++;
    if (p1_rdata !== 16'h0000 || p0_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL p1_write_rdata got p1=%h p0=%h required p1=0000 p0=beef", p1_rdata,
               p0_rdata);
    end
    checks++;
    if (grant !== 1'b1) begin errors++; $display("FAIL p1_write_grant got %b required 1", grant); end
  endtask

  task automatic test_round_robin;
    logic order [4];
    logic exp_order [4];
    int n = 0;
`ifdef SPI_ARB_FIXED_PRIO_EN
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    k_cfg = 2;
    @(posedge clk); #1;
    p0_req = 1; p0_we = 0; p0_addr = 16'h0100;
    p1_req = 1; p1_we = 0; p1_addr = 16'h0200;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (p0_done || p1_done) begin
        order[n] = p1_done;
        n++;
        if (n == 4) begin
          p0_req = 0;
          p1_req = 0;
          break;
        end
      end
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL rr_count got %0d required 4", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (order[i] !== exp_order[i]) begin
        errors++;
        $display("FAIL rr_grant_%0d got %b required %b", i, order[i], exp_order[i]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_addr_hold;
    int sw0 = sw_cnt;
    bit seen = 0;
    bit ok = 0;
    k_cfg = 10;
    @(posedge clk); #1;
    p0_req = 1; p0_we = 0; p0_addr = 16'h0002; p0_wdata = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ram_start_read) begin seen = 1; break; end
    end
    @(negedge clk);
    p0_addr = 16'hFFFF; p0_we = 1; p0_wdata = 16'h1111;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (p0_done) begin ok = 1; break; end
    end
    checks++;
    if (!(seen && ok)) begin
      errors++; $display("FAIL hold_timeout got start=%b done=%b required 1/1", seen, ok);
    end
    checks++;
    if (ram_addr !== 16'h0002) begin
      errors++; $display("FAIL hold_addr got %h required 0002", ram_addr);
    end
    checks++;
    if (p0_rdata !== 16'h5A5A || sw_cnt != sw0) begin
      errors++;
      $display("FAIL hold_data got %h writes=%0d required 5a5a writes=0", p0_rdata, sw_cnt - sw0);
    end
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit ok = 0;
    k_cfg = 20;
    @(posedge clk); #1;
    p1_req = 1; p1_we = 0; p1_addr = 16'h0003;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ram_start_read) break;
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({arb_busy, grant, ram_start_read, ram_start_write, p0_done, p1_done} !== 6'b0) begin
      errors++;
      $display("FAIL midrst_ctrl got %b required 000000",
               {arb_busy, grant, ram_start_read, ram_start_write, p0_done, p1_done});
    end
    checks++;
    if ({ram_addr, p0_rdata} !== 32'h0) begin
      errors++; $display("FAIL midrst_data got %h required 00000000", {ram_addr, p0_rdata});
    end
    p1_req = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (arb_busy !== 1'b0) begin errors++; $display("FAIL midrst_idle got %b required 0", arb_busy); end
    k_cfg = 2;
    @(posedge clk); #1;
    p0_req = 1; p0_addr = 16'h0004; p1_req = 1; p1_addr = 16'h0005;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (p0_done || p1_done) begin ok = 1; break; end
    end
    checks++;
    if (!ok || p0_done !== 1'b1 || p1_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_tie got p0_done=%b p1_done=%b required 1/0", p0_done, p1_done);
    end
    p0_req = 0; p1_req = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int sr0 = sr_cnt, d00 = d0_cnt, d10 = d1_cnt;
    bit ok1, ok2;
    run_txn(1'b1, 1'b0, 16'h0040, 16'h0000, 1, ok1);
    run_txn(1'b0, 1'b0, 16'h0041, 16'h0000, 1, ok2);
    checks++;
    if (!(ok1 && ok2)) begin
      errors++; $display("FAIL b2b_timeout got %b%b required 11", ok1, ok2);
    end
    checks++;
    if (p1_rdata !== 16'hC383 || p0_rdata !== 16'hC382) begin
      errors++;
      $display("FAIL b2b_data got p1=%h p0=%h required p1=c383 p0=c382", p1_rdata, p0_rdata);
    end
    checks++;
    if (sr_cnt - sr0 != 2 || d0_cnt - d00 != 1 || d1_cnt - d10 != 1) begin
      errors++;
      $display("FAIL b2b_pulses got starts=%0d d0=%0d d1=%0d required 2/1/1", sr_cnt - sr0,
               d0_cnt - d00, d1_cnt - d10);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_p0_read();
    test_p1_write();
    test_round_robin();
    test_addr_hold();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    errors = errors + asrt_fail;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
